// File: rtl/modport_vco_pkg.sv
// -----------------------------------------------------------------------------
// modport_vco_pkg
// Shared definitions for the numerically controlled sine oscillator:
//   - default phase accumulator width and base phase increment
//   - 64-entry quarter-wave magnitude table, Q[i] = round(127*sin(2*pi*(i+0.5)/256))
//   - quadrant encoding of the top two waveform address bits
// -----------------------------------------------------------------------------
package modport_vco_pkg;

  localparam int DEF_PHASE_W  = 16;
  localparam int DEF_BASE_INC = 256;

  // Quadrant taken from addr[7:6].
  //   RISE     : first quarter,  positive half, magnitude rising
  //   FALL     : second quarter, positive half, magnitude falling (mirrored index)
  //   NEG_FALL : third quarter,  negative half, level falling (direct index)
  //   NEG_RISE : fourth quarter, negative half, level rising back (mirrored index)
  typedef enum logic [1:0] {
    QUAD_RISE     = 2'd0,
    QUAD_FALL     = 2'd1,
    QUAD_NEG_FALL = 2'd2,
    QUAD_NEG_RISE = 2'd3
  } quad_t;

  // Half-sample offset (i+0.5) keeps the table symmetric about the quarter
  // boundary, so adjacent quadrants meet on equal values (e.g. 255,255 at 63/64).
  localparam logic [6:0] QTAB [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

endpackage

// File: rtl/modport_vco_sine_lut.sv
// -----------------------------------------------------------------------------
// modport_vco_sine_lut
// Combinational 8-bit phase address to 8-bit offset-binary sine sample,
// built from the quarter-wave table by index mirroring and sign folding.
// Ports:
//   addr   in  [7:0]  waveform address (quadrant in [7:6], index in [5:0])
//   sample out [7:0]  sine sample, 0x80 = zero level, range 0..255
// -----------------------------------------------------------------------------
module modport_vco_sine_lut
  import modport_vco_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] sample
);

  quad_t      quad;
  logic [5:0] idx;
  logic [5:0] tab_idx;
  logic [6:0] mag;

  always_comb begin
    quad    = quad_t'(addr[7:6]);
    idx     = addr[5:0];
    tab_idx = idx;
    mag     = 7'd0;
    sample  = 8'h80;

    // Odd quadrants run the table backwards; 63-i is the bitwise inverse of i.
    if (addr[6]) begin
      tab_idx = ~idx;
    end
    mag = QTAB[tab_idx];

    // Positive half sits above 0x80, negative half mirrors below 0x7F, so the
    // extremes land exactly on 255 and 0 without any clamping.
    case (quad)
      QUAD_RISE, QUAD_FALL:         sample = 8'd128 + {1'b0, mag};
      QUAD_NEG_FALL, QUAD_NEG_RISE: sample = 8'd127 - {1'b0, mag};
      default:                      sample = 8'h80;
    endcase
  end

endmodule

// File: rtl/modport_vco.sv
// -----------------------------------------------------------------------------
// modport_vco
// Numerically controlled sine oscillator. A PHASE_W-bit accumulator advances by
// BASE_INC + data_in every clock; its top 8 bits address a quarter-wave sine
// table and the resulting sample is registered onto data_out.
// Output frequency = f_clk * (BASE_INC + data_in) / 2^PHASE_W.
// Parameters:
//   PHASE_W   phase accumulator width (10..24)
//   BASE_INC  fixed phase increment added every cycle
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high; clears phase, parks data_out at 0x80
//   data_in   in   [7:0] unsigned frequency control word
//   data_out  out  [7:0] registered offset-binary sine sample
// -----------------------------------------------------------------------------
module modport_vco
  import modport_vco_pkg::*;
#(
  parameter int                 PHASE_W  = DEF_PHASE_W,
  parameter logic [PHASE_W-1:0] BASE_INC = PHASE_W'(DEF_BASE_INC)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [7:0]         addr;
  logic [7:0]         sample;

  // Modulo-2^PHASE_W sum: overflow is the intended silent wrap.
  assign phase_next = phase + BASE_INC + {{(PHASE_W-8){1'b0}}, data_in};

  // The sample is looked up from the current (pre-update) phase, so data_out
  // lags phase by one edge and data_in never reaches data_out combinationally.
  assign addr = phase[PHASE_W-1 -: 8];

  modport_vco_sine_lut u_sine_lut (
    .addr   (addr),
    .sample (sample)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      data_out <= 8'h80;
    end else begin
      phase    <= phase_next;
      data_out <= sample;
    end
  end

endmodule

// File: tb/tb_modport_vco.sv
// -----------------------------------------------------------------------------
// tb_modport_vco
// Directed bench for modport_vco with default parameters. A reference model
// tracks the phase by its defining formula and derives each sample from $sin,
// alongside hand-computed constants at the notable waveform points.
// -----------------------------------------------------------------------------
module tb_modport_vco;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  int ph_m   = 0;
  int exp_m  = 128;

  modport_vco dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int ref_sample(input int addr);
    int  q;
    int  i;
    int  idx;
    int  qv;
    real s;
    q   = (addr >> 6) & 3;
    i   = addr & 63;
    idx = (q == 1 || q == 3) ? 63 - i : i;
    s   = 127.0 * $sin(2.0 * 3.141592653589793 * (real'(idx) + 0.5) / 256.0);
    qv  = $rtoi(s + 0.5);
    return (q < 2) ? 128 + qv : 127 - qv;
  endfunction

  // Apply one clock edge with the given inputs, advance the model and compare
  // the registered output and the phase register just after the edge.
  task automatic tick(input logic rst, input logic [7:0] din);
    reset   = rst;
    data_in = din;
    @(posedge clk);
    if (rst) begin
      exp_m = 128;
      ph_m  = 0;
    end else begin
      exp_m = ref_sample((ph_m >> 8) & 255);
      ph_m  = (ph_m + 256 + int'(din)) & 32'hFFFF;
    end
    #1;
    check("data_out", {24'd0, data_out}, exp_m);
    check("phase", {16'd0, dut.phase}, ph_m);
  endtask

  initial begin
    int a_before;

    // Reset held three edges with data_in at full scale.
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 8'hFF);
      check("rst_out", {24'd0, data_out}, 32'h80);
      check("rst_phase", {16'd0, dut.phase}, 32'd0);
    end

    // First edge out of reset: addr 0 sample and phase = BASE_INC.
    tick(1'b0, 8'h00);
    check("first_out", {24'd0, data_out}, 32'd130);
    check("first_phase", {16'd0, dut.phase}, 32'd256);

    // Slow sweep across more than one full period, through the 0xFFxx->0x00xx wrap.
    for (int k = 0; k < 300; k++) begin
      a_before = (ph_m >> 8) & 255;
      tick(1'b0, 8'h00);
      if (a_before == 63)  check("peak_a63", {24'd0, data_out}, 32'd255);
      if (a_before == 64)  check("peak_a64", {24'd0, data_out}, 32'd255);
      if (a_before == 191) check("trough_a191", {24'd0, data_out}, 32'd0);
      if (a_before == 192) check("trough_a192", {24'd0, data_out}, 32'd0);
      if (a_before == 255) check("wrap_a255", {24'd0, data_out}, 32'd125);
      if (a_before == 0)   check("wrap_a0", {24'd0, data_out}, 32'd130);
    end

    // Fast rate: 256 + 255 = 511 per edge.
    tick(1'b1, 8'h00);
    for (int k = 0; k < 4; k++) tick(1'b0, 8'hFF);
    check("fast_phase", {16'd0, dut.phase}, 32'd2044);
    check("fast_addr", {24'd0, dut.phase[15:8]}, 32'd7);

    // Keep running fast long enough to wrap the accumulator at least once.
    for (int k = 0; k < 140; k++) tick(1'b0, 8'hFF);

    // Mid-run reset for a single edge.
    tick(1'b1, 8'h5A);
    check("mid_rst_out", {24'd0, data_out}, 32'h80);
    tick(1'b0, 8'h00);
    check("mid_rst_next", {24'd0, data_out}, 32'd130);

    // Latency: phase 256 -> 1024, then data_in steps to 128 (increment 384).
    for (int k = 0; k < 3; k++) tick(1'b0, 8'h00);
    check("lat_pre_phase", {16'd0, dut.phase}, 32'd1024);
    tick(1'b0, 8'd128);
    check("lat_n_phase", {16'd0, dut.phase}, 32'd1408);
    check("lat_n_out", {24'd0, data_out}, 32'd142);
    tick(1'b0, 8'd128);
    check("lat_n1_phase", {16'd0, dut.phase}, 32'd1792);
    check("lat_n1_out", {24'd0, data_out}, 32'd145);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
